add_sub_seq_unit: RTL and testbench

Parametrised multi-cycle adder/subtractor for the ALU datapath.
- Computes a+b or a-b (two's complement, a + ~b + 1) over WIDTH bits, CHUNK bits per clock, using a carry register between chunks.
- Operands are accepted and results returned through valid/ready handshakes, so the block can sit behind a stallable execute stage.
- Trades latency for a short carry chain.

---
 rtl/add_sub_seq_pkg.sv | 22 ++
 rtl/add_sub_chunk.sv | 42 ++++
 rtl/add_sub_seq_unit.sv | 198 +++++++++++++++++++
 tb/tb_add_sub_seq_unit.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_sub_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : add_sub_seq_pkg
// Purpose : Shared types and constants for the sequential adder/subtractor.
//           Contents:
//             state_e     - control state encoding (IDLE / BUSY / DONE)
//             SUB_SEL_BIT - index of the subtract-select bit in
//                           alu_control_signal
// Revision: 1.0 - initial release
// ============================================================================
package add_sub_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int SUB_SEL_BIT = 3;

endpackage
`default_nettype wire

// File: rtl/add_sub_chunk.sv
`default_nettype none
// ============================================================================
// Module  : add_sub_chunk
// Purpose : CHUNK-bit combinational adder slice with carry in/out.
//           Build option: ADD_SUB_SEQ_FLAGS_EN adds msb_cin, the carry into
//           the slice MSB, which feeds the signed-overflow flag.
// Ports   :
//   a, b     in  CHUNK  addend slices (b already inverted for subtract)
//   cin      in  1      carry in
//   sum      out CHUNK  slice sum
//   cout     out 1      carry out of slice MSB
//   msb_cin  out 1      carry into slice MSB (ADD_SUB_SEQ_FLAGS_EN only)
// Revision: 1.0 - initial release
// ============================================================================
module add_sub_chunk #(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
`ifdef ADD_SUB_SEQ_FLAGS_EN
  ,
  output logic             msb_cin
`endif
);

  logic [CHUNK:0] full_sum;

  assign full_sum = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
  assign sum      = full_sum[CHUNK-1:0];
  assign cout     = full_sum[CHUNK];

`ifdef ADD_SUB_SEQ_FLAGS_EN
  // The MSB sum bit is a ^ b ^ carry_in, so the carry into it falls out
  // by XOR-ing the operand bits back off.
  assign msb_cin = a[CHUNK-1] ^ b[CHUNK-1] ^ sum[CHUNK-1];
`endif

endmodule
`default_nettype wire

// File: rtl/add_sub_seq_unit.sv
`default_nettype none
// ============================================================================
// Module  : add_sub_seq_unit
// Purpose : Multi-cycle WIDTH-bit adder/subtractor that processes CHUNK bits
//           per clock through one shared add_sub_chunk slice, with a carry
//           register between slices. Operands and results move through
//           valid/ready handshakes.
//           Build option: ADD_SUB_SEQ_FLAGS_EN adds overflow/zero outputs.
// Ports   :
//   clk                 in  1      clock, all state on posedge
//   rst                 in  1      synchronous reset, active-high
//   in_valid            in  1      operands valid
//   in_ready            out 1      block can accept operands (IDLE)
//   a, b                in  WIDTH  operands
//   alu_control_signal  in  4      bit 3: 1 = subtract, 0 = add
//   out_valid           out 1      result valid (DONE)
//   out_ready           in  1      consumer accepts result
//   result              out WIDTH  sum/difference mod 2^WIDTH
//   Cout                out 1      carry out of MSB (subtract: 1 = no borrow)
//   overflow            out 1      signed overflow (ADD_SUB_SEQ_FLAGS_EN)
//   zero                out 1      result == 0     (ADD_SUB_SEQ_FLAGS_EN)
// Revision: 1.0 - initial release
// ============================================================================
module add_sub_seq_unit
  import add_sub_seq_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_control_signal,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             Cout
`ifdef ADD_SUB_SEQ_FLAGS_EN
  ,
  output logic             overflow,
  output logic             zero
`endif
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NCHUNK - 1);

  generate
    if ((CHUNK <= 0) || (WIDTH % CHUNK != 0)) begin : g_chunk_check
      $error("add_sub_seq_unit: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  state_e             state_q,  state_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic               carry_q,  carry_d;
  logic [WIDTH-1:0]   a_q,      a_d;
  logic [WIDTH-1:0]   b_q,      b_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               cout_q,   cout_d;
`ifdef ADD_SUB_SEQ_FLAGS_EN
  logic               ovf_q,    ovf_d;
  logic               zero_q,   zero_d;
  logic               chunk_msb_cin;
`endif

  logic               sub;
  logic [CHUNK-1:0]   a_chunk;
  logic [CHUNK-1:0]   b_chunk;
  logic [CHUNK-1:0]   chunk_sum;
  logic               chunk_cout;
  logic               unused_ctrl_bits;

  assign sub              = alu_control_signal[SUB_SEL_BIT];
  assign unused_ctrl_bits = ^alu_control_signal[2:0];

  // Select the slice addressed by the chunk counter.
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        a_chunk = a_q[k*CHUNK +: CHUNK];
        b_chunk = b_q[k*CHUNK +: CHUNK];
      end
    end
  end

  add_sub_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a       (a_chunk),
    .b       (b_chunk),
    .cin     (carry_q),
    .sum     (chunk_sum),
    .cout    (chunk_cout)
`ifdef ADD_SUB_SEQ_FLAGS_EN
    ,
    .msb_cin (chunk_msb_cin)
`endif
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cout_d   = cout_q;
`ifdef ADD_SUB_SEQ_FLAGS_EN
    ovf_d    = ovf_q;
    zero_d   = zero_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          // Subtract is a + ~b + 1: B is stored inverted and the +1 enters
          // as the initial carry, so the op bit needs no register of its own.
          a_d     = a;
          b_d     = b ^ {WIDTH{sub}};
          carry_d = sub;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        for (int k = 0; k < NCHUNK; k++) begin
          if (cnt_q == CNT_W'(k)) begin
            result_d[k*CHUNK +: CHUNK] = chunk_sum;
          end
        end
        carry_d = chunk_cout;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_CHUNK) begin
          cout_d  = chunk_cout;
          cnt_d   = '0;
          state_d = ST_DONE;
`ifdef ADD_SUB_SEQ_FLAGS_EN
          ovf_d   = chunk_msb_cin ^ chunk_cout;
          zero_d  = (result_d == '0);
`endif
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
`ifdef ADD_SUB_SEQ_FLAGS_EN
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cout_q   <= cout_d;
`ifdef ADD_SUB_SEQ_FLAGS_EN
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign Cout      = cout_q;
`ifdef ADD_SUB_SEQ_FLAGS_EN
  assign overflow  = ovf_q;
  assign zero      = zero_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_add_sub_seq_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_add_sub_seq_unit
// Purpose : Directed self-checking bench for add_sub_seq_unit. Instantiates
//           the default 64/16 configuration and a 32/32 single-slice one.
//           Flag outputs are checked when ADD_SUB_SEQ_FLAGS_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module tb_add_sub_seq_unit;

  logic        clk;
  logic        rst;

  // 64-bit, 16-bit chunk instance
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic [3:0]  ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        cout;

  // 32-bit, single chunk instance
  logic        in_valid2;
  logic        in_ready2;
  logic [31:0] a2;
  logic [31:0] b2;
  logic [3:0]  ctrl2;
  logic        out_valid2;
  logic        out_ready2;
  logic [31:0] result2;
  logic        cout2;

`ifdef ADD_SUB_SEQ_FLAGS_EN
  logic        overflow;
  logic        zero;
  logic        overflow2;
  logic        zero2;
`endif

  logic        unused_flag_sink;
  int          n_assert;
  int          n_fail;

  add_sub_seq_unit #(.WIDTH(64), .CHUNK(16)) dut (
    .clk                (clk),
    .rst                (rst),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .a                  (a),
    .b                  (b),
    .alu_control_signal (ctrl),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .result             (result),
    .Cout               (cout)
`ifdef ADD_SUB_SEQ_FLAGS_EN
    ,
    .overflow           (overflow),
    .zero               (zero)
`endif
  );

  add_sub_seq_unit #(.WIDTH(32), .CHUNK(32)) dut2 (
    .clk                (clk),
    .rst                (rst),
    .in_valid           (in_valid2),
    .in_ready           (in_ready2),
    .a                  (a2),
    .b                  (b2),
    .alu_control_signal (ctrl2),
    .out_valid          (out_valid2),
    .out_ready          (out_ready2),
    .result             (result2),
    .Cout               (cout2)
`ifdef ADD_SUB_SEQ_FLAGS_EN
    ,
    .overflow           (overflow2),
    .zero               (zero2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op to the 64-bit instance (called at a negedge, out_ready=1)
  // and check latency, result, carry and flags.
  task automatic run_op(input string tag, input logic [63:0] ia, input logic [63:0] ib,
                        input logic [3:0] ictrl, input logic [63:0] eres,
                        input logic ecout, input logic eovf, input logic ezero);
    int lat;
    chk({tag, "_in_ready"}, in_ready, 1);
    in_valid = 1'b1;
    a        = ia;
    b        = ib;
    ctrl     = ictrl;
    @(negedge clk);
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd4);
    chk({tag, "_result"}, result, eres);
    chk({tag, "_cout"}, cout, ecout);
`ifdef ADD_SUB_SEQ_FLAGS_EN
    chk({tag, "_overflow"}, overflow, eovf);
    chk({tag, "_zero"}, zero, ezero);
`else
    unused_flag_sink = eovf ^ ezero;
`endif
    @(negedge clk);
    chk({tag, "_back_idle"}, in_ready, 1);
  endtask

  // Same for the 32-bit single-chunk instance; expected values from a
  // whole-word model.
  task automatic run_op2(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                         input logic isub);
    int          lat;
    logic [31:0] bb;
    logic [32:0] full;
    logic        eovf;
    bb   = isub ? ~ib : ib;
    full = {1'b0, ia} + {1'b0, bb} + {32'd0, isub};
    eovf = (ia[31] == bb[31]) && (full[31] != ia[31]);
    chk({tag, "_in_ready"}, in_ready2, 1);
    in_valid2 = 1'b1;
    a2        = ia;
    b2        = ib;
    ctrl2     = {isub, 3'b000};
    @(negedge clk);
    in_valid2 = 1'b0;
    lat = 0;
    while (!out_valid2 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd1);
    chk({tag, "_result"}, 64'(result2), 64'(full[31:0]));
    chk({tag, "_cout"}, cout2, full[32]);
`ifdef ADD_SUB_SEQ_FLAGS_EN
    chk({tag, "_overflow"}, overflow2, eovf);
    chk({tag, "_zero"}, zero2, (full[31:0] == 32'd0));
`else
    unused_flag_sink = eovf;
`endif
    @(negedge clk);
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    unused_flag_sink = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    ctrl      = '0;
    out_ready = 1'b1;
    in_valid2 = 1'b0;
    a2        = '0;
    b2        = '0;
    ctrl2     = '0;
    out_ready2 = 1'b1;

    // Reset and idle for 10 cycles
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_result", result, 64'd0);
      chk("rst_cout", cout, 0);
`ifdef ADD_SUB_SEQ_FLAGS_EN
      chk("rst_overflow", overflow, 0);
      chk("rst_zero", zero, 0);
`endif
      @(negedge clk);
    end

    // Directed vectors (hand-computed)
    run_op("add_all_ones_plus1", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0000,
           64'd0, 1'b1, 1'b0, 1'b1);
    run_op("sub_5_7", 64'd5, 64'd7, 4'b1000,
           64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run_op("sub_7_5", 64'd7, 64'd5, 4'b1000,
           64'd2, 1'b1, 1'b0, 1'b0);
    run_op("add_signed_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'b0000,
           64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
    run_op("add_mid_carries", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 4'b0000,
           64'h2222_2222_2222_2211, 1'b0, 1'b0, 1'b0);
    run_op("sub_min_minus1", 64'h8000_0000_0000_0000, 64'd1, 4'b1000,
           64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0);
    run_op("sub_equal", 64'hDEAD_BEEF_0000_1111, 64'hDEAD_BEEF_0000_1111, 4'b1000,
           64'd0, 1'b1, 1'b0, 1'b1);
    run_op("add_low_ctrl_ignored", 64'd3, 64'd4, 4'b0111,
           64'd7, 1'b0, 1'b0, 1'b0);
    run_op("sub_low_ctrl_ignored", 64'd3, 64'd4, 4'b1111,
           64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);

    // Backpressure: hold DONE for 6 cycles with a stray in_valid
    out_ready = 1'b0;
    begin
      int lat;
      in_valid = 1'b1;
      a        = 64'd1;
      b        = 64'd2;
      ctrl     = 4'b0000;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      chk("bp_latency", 64'(lat), 64'd4);
    end
    for (int i = 0; i < 6; i++) begin
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_result", result, 64'd3);
      chk("bp_cout", cout, 0);
      in_valid = 1'b1;
      a        = 64'hFFFF_FFFF_FFFF_FFFF;
      b        = 64'hFFFF_FFFF_FFFF_FFFF;
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_out_valid", out_valid, 0);
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_release_result_held", result, 64'd3);
    run_op("after_bp", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 4'b0000,
           64'h2222_2222_2222_2211, 1'b0, 1'b0, 1'b0);

    // Reset in the second BUSY cycle
    in_valid = 1'b1;
    a        = 64'h0000_0000_0000_1111;
    b        = 64'h0000_0000_0000_2222;
    ctrl     = 4'b0000;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_result", result, 64'd0);
    chk("midrst_cout", cout, 0);
    repeat (6) @(negedge clk);
    chk("midrst_stays_idle", out_valid, 0);
    run_op("after_midrst", 64'd7, 64'd5, 4'b1000,
           64'd2, 1'b1, 1'b0, 1'b0);

    // Single-chunk configuration
    chk("w32_rst_result", 64'(result2), 64'd0);
    run_op2("w32_wrap", 32'hFFFF_FFFF, 32'd1, 1'b0);
    run_op2("w32_sub_borrow", 32'd5, 32'd7, 1'b1);
    for (int i = 0; i < 6; i++) begin
      run_op2("w32_rand", 32'($urandom), 32'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
